pp_pipeline_accel_fifo_srl_gen: RTL and testbench
=================================================

PP_PIPELINE_ACCEL_FIFO_SRL_GEN -- requirements
Module: pp_pipeline_accel_fifo_srl_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 64, payload width in bits.
REQ-002 Parameter DEPTH, default 4, storage entries; legal values are 2..64.
REQ-003 Parameter ADDR_WIDTH, default clog2(DEPTH), read-address width.
REQ-004 Parameter AFULL_LVL, default DEPTH-1, occupancy at or above which almost-full asserts.
REQ-005 Parameter AEMPTY_LVL, default 1, occupancy at or below which almost-empty asserts.
REQ-006 Ports, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high when a write can be accepted.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  head-of-queue data (first-word fall-through).
- if_empty_n  out  1  high when if_dout is valid.
- if_flush  in  1  synchronous discard of all contents.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.
- if_almost_full_n  out  1  low when occupancy >= AFULL_LVL.
- if_almost_empty_n  out  1  low when occupancy <= AEMPTY_LVL.
- if_overflow  out  1  sticky flag: a write was attempted while full.
- if_underflow  out  1  sticky flag: a read was attempted while empty.
- if_max_level  out  ADDR_WIDTH+1  peak occupancy since the last reset or flush.

Function
REQ-007 Write fire is if_write & if_write_ce & if_full_n; read fire is if_read & if_read_ce & if_empty_n.
REQ-008 Write fire alone: occupancy +1, if_din shifts into entry 0, all entries shift up by one.
REQ-009 Read fire alone: occupancy -1; no data moves.
REQ-010 Write fire and read fire together: occupancy is unchanged and the shift still occurs.
REQ-011 When full, a write is refused even if a read fires in the same cycle; the read completes and if_full_n rises the next cycle.
REQ-012 if_dout shall equal the entry at address occupancy-1 combinationally (zero-latency head); its value when empty is don't-care.
REQ-013 All status outputs (if_full_n, if_empty_n, occupancy, if_almost_full_n, if_almost_empty_n) shall be registered and reflect post-edge occupancy with no extra cycle of lag.
REQ-014 A write request while full (if_write & if_write_ce & ~if_full_n) sets if_overflow; the FIFO state is otherwise unchanged.
REQ-015 A read request while empty sets if_underflow; the FIFO state is otherwise unchanged.
REQ-016 if_max_level updates to the new occupancy whenever the new occupancy exceeds it.
REQ-017 if_flush has priority over read and write in the same cycle; on the next edge:
- occupancy becomes 0;
- if_empty_n becomes 0 and if_full_n becomes 1;
- if_overflow, if_underflow and if_max_level clear;
- storage contents are left untouched.
REQ-018 Occupancy arithmetic is ADDR_WIDTH+1 bits wide and shall never wrap; it is bounded to 0..DEPTH by the fire rules.

Reset
REQ-019 On reset, outputs take these values:
- occupancy = 0;
- if_empty_n = 0, if_full_n = 1;
- if_almost_empty_n = 0, if_almost_full_n = 1, or 0 if AFULL_LVL = 0;
- if_overflow = 0, if_underflow = 0, if_max_level = 0.
REQ-020 Reset overrides flush, read and write, and storage is not reset.
REQ-021 Reset asserted mid-burst discards all in-flight data within one cycle.
REQ-022 Registers shall carry power-up initial values equal to their reset values.

Structure
REQ-023 A shared package pp_pipeline_accel_fifo_pkg holds the clog2 function and the parameter-legality checks (DEPTH range, AFULL_LVL <= DEPTH, AEMPTY_LVL < DEPTH).
REQ-024 Storage is one sub-module, pp_pipeline_accel_fifo_srl_gen_shiftReg (clk, data, ce, a, q), with an SRL-inferable style: no reset and a single clock enable.
REQ-025 Control (occupancy, flags, peak tracking) lives in the top module.

Verification
REQ-026 Bench runs with DEPTH=4, DATA_WIDTH=64, AFULL_LVL=3, AEMPTY_LVL=1 and covers these scenarios:
- Write 0xA..0xD in consecutive cycles: full_n=0 after the 4th edge, almost_full_n=0 after the 3rd; reads then return 0xA,0xB,0xC,0xD in order.
- When full, assert read and write of 0xE together: 0xA is popped, 0xE is dropped, overflow=1, num_data_valid=3.
- With occupancy 2, simultaneous read+write of 0x55: num_data_valid stays 2 and the next dout values are the old second entry, then 0x55.
- Read while empty: underflow=1, empty_n stays 0, num_data_valid stays 0.
- Fill to 3, then assert flush together with a write: num_data_valid=0, max_level=0, overflow=0, empty_n=0 on the next cycle.
- Assert reset after two writes: every output matches REQ-019 values one edge later, and max_level reads 0.

Source files
------------

// File: rtl/pp_pipeline_accel_fifo_pkg.sv
// Shared helpers for the shift-register FIFO: width calculation, parameter
// legality and the per-cycle operation encoding.
package pp_pipeline_accel_fifo_pkg;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 64;

  // Combined write/read fire, packed as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE     = 2'b00,
    OP_POP      = 2'b01,
    OP_PUSH     = 2'b10,
    OP_PUSH_POP = 2'b11
  } op_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic bit params_legal(input int depth, input int afull_lvl,
                                      input int aempty_lvl, input int addr_width);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           (afull_lvl >= 0) && (afull_lvl <= depth) &&
           (aempty_lvl >= 0) && (aempty_lvl < depth) &&
           (addr_width >= clog2(depth));
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl_gen_shiftReg.sv
// Shift-register storage: new data enters entry 0 and everything moves up one.
// Written so that synthesis can map it onto SRL primitives.
module pp_pipeline_accel_fifo_srl_gen_shiftReg #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] sreg [DEPTH];

  // NOTE: storage has no reset on purpose; a reset or a clear term would stop
  // it mapping onto shift-register primitives, and occupancy alone says which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (ce) begin
      sreg[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        sreg[i] <= sreg[i-1];
      end
    end
  end

  assign q = sreg[a];

endmodule

// File: rtl/pp_pipeline_accel_fifo_srl_gen.sv
// First-word-fall-through FIFO over a shift register: occupancy, registered
// status flags, sticky overflow/underflow and peak-occupancy tracking.
module pp_pipeline_accel_fifo_srl_gen
  import pp_pipeline_accel_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_flush,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n,
  output logic                  if_overflow,
  output logic                  if_underflow,
  output logic [ADDR_WIDTH:0]   if_max_level
);

  localparam int CW = ADDR_WIDTH + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C       = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C       = cnt_t'(AFULL_LVL);
  localparam cnt_t AEMPTY_C      = cnt_t'(AEMPTY_LVL);
  localparam logic AFULL_N_RST   = (AFULL_LVL > 0);

  if (!params_legal(DEPTH, AFULL_LVL, AEMPTY_LVL, ADDR_WIDTH)) begin : g_bad_params
    $error("pp_pipeline_accel_fifo_srl_gen: illegal DEPTH/AFULL_LVL/AEMPTY_LVL/ADDR_WIDTH");
  end

  // Power-up values match the reset values so the FIFO is usable before reset.
  cnt_t count_q    = '0;
  cnt_t max_q      = '0;
  logic full_n_q   = 1'b1;
  logic empty_n_q  = 1'b0;
  logic afull_n_q  = AFULL_N_RST;
  logic aempty_n_q = 1'b0;
  logic ovf_q      = 1'b0;
  logic unf_q      = 1'b0;

  cnt_t count_d, max_d;
  logic full_n_d, empty_n_d, afull_n_d, aempty_n_d, ovf_d, unf_d;
  logic wr_req, rd_req, wr_fire, rd_fire, shift_ce;
  op_e  op;

  assign wr_req   = if_write & if_write_ce;
  assign rd_req   = if_read & if_read_ce;
  assign wr_fire  = wr_req & full_n_q;
  assign rd_fire  = rd_req & empty_n_q;
  assign op       = op_e'({wr_fire, rd_fire});
  assign shift_ce = wr_fire & ~if_flush & ~reset;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (if_flush) begin
      count_d = '0;
      max_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (op)
        OP_PUSH: count_d = count_q + cnt_t'(1);
        OP_POP:  count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (wr_req & ~full_n_q);
      unf_d = unf_q | (rd_req & ~empty_n_q);
      max_d = (count_d > max_q) ? count_d : max_q;
    end
  end

  // Flags are derived from next-state occupancy so the registered outputs
  // line up with the count on the same edge.
  assign full_n_d   = (count_d != DEPTH_C);
  assign empty_n_d  = (count_d != '0);
  assign afull_n_d  = (count_d < AFULL_C);
  assign aempty_n_d = (count_d > AEMPTY_C);

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      max_q      <= '0;
      full_n_q   <= 1'b1;
      empty_n_q  <= 1'b0;
      afull_n_q  <= AFULL_N_RST;
      aempty_n_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      max_q      <= max_d;
      full_n_q   <= full_n_d;
      empty_n_q  <= empty_n_d;
      afull_n_q  <= afull_n_d;
      aempty_n_q <= aempty_n_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  pp_pipeline_accel_fifo_srl_gen_shiftReg #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk  (clk),
    .data (if_din),
    .ce   (shift_ce),
    .a    (ADDR_WIDTH'(count_q - cnt_t'(1))),
    .q    (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_almost_full_n  = afull_n_q;
  assign if_almost_empty_n = aempty_n_q;
  assign if_overflow       = ovf_q;
  assign if_underflow      = unf_q;
  assign if_num_data_valid = count_q;
  assign if_max_level      = max_q;
  assign if_fifo_cap       = DEPTH_C;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_gen.sv
// Scoreboard bench: a queue-based reference model predicts status and popped
// data; a negedge monitor compares head data whenever a pop is presented.
module tb_pp_pipeline_accel_fifo_srl_gen;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_write_ce = 1'b0, if_write = 1'b0;
  logic          if_read_ce = 1'b0, if_read = 1'b0;
  logic          if_flush = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic [DW-1:0] if_dout;
  logic          if_full_n, if_empty_n, if_almost_full_n, if_almost_empty_n;
  logic          if_overflow, if_underflow;
  logic [AW:0]   if_num_data_valid, if_fifo_cap, if_max_level;

  pp_pipeline_accel_fifo_srl_gen #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (3),
    .AEMPTY_LVL (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_full_n         (if_full_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_empty_n        (if_empty_n),
    .if_flush          (if_flush),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap),
    .if_almost_full_n  (if_almost_full_n),
    .if_almost_empty_n (if_almost_empty_n),
    .if_overflow       (if_overflow),
    .if_underflow      (if_underflow),
    .if_max_level      (if_max_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];   // expected pop data, oldest first
  logic [DW-1:0] mq[$];      // reference FIFO contents, head at index 0
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  int            m_max = 0;

  logic [11:0] dut_status;
  assign dut_status = {if_num_data_valid, if_max_level, if_full_n, if_empty_n,
                       if_almost_full_n, if_almost_empty_n, if_overflow, if_underflow};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_status();
    int n;
    n = mq.size();
    return {3'(n), 3'(m_max), 1'(n != DEPTH), 1'(n != 0), 1'(n < 3), 1'(n > 1),
            1'(m_ovf), 1'(m_unf)};
  endfunction

  // Drive one cycle, predict its effect, then check status after the edge.
  task automatic step(input bit wi, input bit wcei, input logic [DW-1:0] d, input bit ri,
                      input bit rcei, input bit fl, input bit rs, input string tag);
    bit wr_ok, rd_ok;
    reset = rs; if_write = wi; if_write_ce = wcei; if_din = d;
    if_read = ri; if_read_ce = rcei; if_flush = fl;
    if (rs || fl) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_max = 0;
    end else begin
      if (wi && wcei && mq.size() == DEPTH) m_ovf = 1'b1;
      if (ri && rcei && mq.size() == 0) m_unf = 1'b1;
      wr_ok = wi && wcei && (mq.size() < DEPTH);
      rd_ok = ri && rcei && (mq.size() > 0);
      if (rd_ok) exp_q.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(d);
      if (mq.size() > m_max) m_max = mq.size();
    end
    @(posedge clk);
    #1;
    check({tag, " status"}, 64'(dut_status), 64'(exp_status()));
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic wr(input logic [DW-1:0] d, input string tag);
    step(1'b1, 1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic rd(input string tag);
    step(1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b0, tag);
  endtask

  // Monitor: a pop is presented when read is requested and the FIFO says valid.
  always @(negedge clk) begin
    if (!reset && !if_flush && if_read && if_read_ce && if_empty_n) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dout unexpected pop: got 0x%0h with nothing expected", if_dout);
      end else begin
        check("dout", if_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    check("fifo_cap", 64'(if_fifo_cap), 64'd4);

    // Fill with 0xA..0xD, then drain in order.
    for (int i = 0; i < 4; i++) begin
      wr(64'hA + 64'(i), "fill");
      if (i == 2) check("almost_full_n after 3 writes", 64'(if_almost_full_n), 64'd0);
      if (i == 3) check("full_n after 4 writes", 64'(if_full_n), 64'd0);
    end
    for (int i = 0; i < 4; i++) rd("drain");

    // Full: simultaneous read and write drops the write and flags overflow.
    for (int i = 0; i < 4; i++) wr(64'hA + 64'(i), "refill");
    step(1'b1, 1'b1, 64'hE, 1'b1, 1'b1, 1'b0, 1'b0, "full rw");
    check("overflow when full", 64'(if_overflow), 64'd1);
    check("count after full rw", 64'(if_num_data_valid), 64'd3);
    for (int i = 0; i < 3; i++) rd("drain2");

    // Read while empty.
    rd("empty read");
    check("underflow", 64'(if_underflow), 64'd1);
    check("empty_n after empty read", 64'(if_empty_n), 64'd0);
    check("count after empty read", 64'(if_num_data_valid), 64'd0);

    // Occupancy 2 with simultaneous read+write.
    wr(64'h11, "pre2"); wr(64'h22, "pre2");
    step(1'b1, 1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 1'b0, "rw at 2");
    check("count after rw at 2", 64'(if_num_data_valid), 64'd2);
    rd("post rw"); rd("post rw");

    // Flush with a concurrent write.
    for (int i = 0; i < 3; i++) wr(64'h100 + 64'(i), "pre flush");
    step(1'b1, 1'b1, 64'hF0, 1'b0, 1'b1, 1'b1, 1'b0, "flush");
    check("count after flush", 64'(if_num_data_valid), 64'd0);
    check("max_level after flush", 64'(if_max_level), 64'd0);
    check("overflow after flush", 64'(if_overflow), 64'd0);
    check("empty_n after flush", 64'(if_empty_n), 64'd0);

    // Reset after two writes.
    wr(64'h77, "pre reset"); wr(64'h88, "pre reset");
    step(1'b1, 1'b1, 64'h99, 1'b1, 1'b1, 1'b0, 1'b1, "mid reset");
    check("max_level after reset", 64'(if_max_level), 64'd0);
    check("reset outputs", 64'(dut_status), 64'b000_000_1_0_1_0_0_0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 59) == 0), "rand");
    end

    idle("final");
    @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
